// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, two byte-enabled write ports
// (port 1 wins per byte), optional zero r0, write-first bypass and registered reads.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   R_Addr,
    output logic [NUM_RD*DATA_W-1:0]   R_Data,
    output logic [NUM_RD-1:0]          R_Valid,
    input  logic                       Write_Reg_0,
    input  logic [ADDR_W-1:0]          W_Addr_0,
    input  logic [DATA_W-1:0]          W_Data_0,
    input  logic [DATA_W/8-1:0]        W_BE_0,
    input  logic                       Write_Reg_1,
    input  logic [ADDR_W-1:0]          W_Addr_1,
    input  logic [DATA_W-1:0]          W_Data_1,
    input  logic [DATA_W/8-1:0]        W_BE_1
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0]             sel0, sel1;
    logic                         hit0, hit1;
    logic [NUM_RD*DATA_W-1:0]     rd_data_d;
    logic [NUM_RD-1:0]            rd_vld_d;

    function automatic logic wr_ok(input logic we, input logic [ADDR_W-1:0] a);
        return we && ({1'b0, a} < DEPTH_L) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    // Port 1 owns every byte it enables; port 0 fills only the remaining ones.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] cur,
        input logic              s0,
        input logic [DATA_W-1:0] d0,
        input logic [NB-1:0]     be0,
        input logic              s1,
        input logic [DATA_W-1:0] d1,
        input logic [NB-1:0]     be1
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < NB; b++) begin
            if (s1 && be1[b])
                res[b*8 +: 8] = d1[b*8 +: 8];
            else if (s0 && be0[b])
                res[b*8 +: 8] = d0[b*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        hit0  = wr_ok(Write_Reg_0, W_Addr_0);
        hit1  = wr_ok(Write_Reg_1, W_Addr_1);
        sel0  = '0;
        sel1  = '0;
        mem_d = mem_q;
        vld_d = vld_q;
        for (int r = 0; r < DEPTH; r++) begin
            sel0[r]  = hit0 && (W_Addr_0 == ADDR_W'(r));
            sel1[r]  = hit1 && (W_Addr_1 == ADDR_W'(r));
            mem_d[r] = merge_bytes(mem_q[r], sel0[r], W_Data_0, W_BE_0,
                                   sel1[r], W_Data_1, W_BE_1);
            vld_d[r] = vld_q[r] | (sel0[r] && (|W_BE_0)) | (sel1[r] && (|W_BE_1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
            vld_q <= '0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
        end
    end

    // Bypass reads the post-merge image, so forwarding obeys the same byte rules as the write.
    always_comb begin
        rd_data_d = '0;
        rd_vld_d  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (R_Addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = (BYPASS != 0) ? mem_d[r] : mem_q[r];
                    rd_vld_d[i]                   = (BYPASS != 0) ? vld_d[r] : vld_q[r];
                end
            end
            if ((ZERO_R0 != 0) && (R_Addr[i*ADDR_W +: ADDR_W] == '0)) begin
                rd_data_d[i*DATA_W +: DATA_W] = '0;
                rd_vld_d[i]                   = 1'b1;
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_comb_rd
            assign R_Data  = reset ? rd_data_d : '0;
            assign R_Valid = reset ? rd_vld_d  : '0;
        end else begin : g_reg_rd
            logic [NUM_RD*DATA_W-1:0] rd_data_q;
            logic [NUM_RD-1:0]        rd_vld_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data_q <= '0;
                    rd_vld_q  <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                    rd_vld_q  <= rd_vld_d;
                end
            end

            assign R_Data  = rd_data_q;
            assign R_Valid = rd_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: four configurations share one stimulus stream;
// expected read results are queued with a due cycle and checked at the falling edge.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ra0 = '0, ra1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  wa0 = '0, wa1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [3:0]  be0 = '0, be1 = '0;
    logic [63:0] rdat [4];
    logic [1:0]  rvld [4];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          due;
        int          dut;
        int          port;
        logic [31:0] d;
        logic        v;
        logic [63:0] tag;
    } exp_t;
    exp_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0: comb+bypass, dut1: comb no bypass, dut2: registered write-first DEPTH=24, dut3: registered read-first
    regfile_mp #(.READ_LAT(0), .BYPASS(1), .DEPTH(32)) u_d0 (
        .clk(clk), .reset(reset), .R_Addr({ra1, ra0}), .R_Data(rdat[0]), .R_Valid(rvld[0]),
        .Write_Reg_0(we0), .W_Addr_0(wa0), .W_Data_0(wd0), .W_BE_0(be0),
        .Write_Reg_1(we1), .W_Addr_1(wa1), .W_Data_1(wd1), .W_BE_1(be1));
    regfile_mp #(.READ_LAT(0), .BYPASS(0), .DEPTH(32)) u_d1 (
        .clk(clk), .reset(reset), .R_Addr({ra1, ra0}), .R_Data(rdat[1]), .R_Valid(rvld[1]),
        .Write_Reg_0(we0), .W_Addr_0(wa0), .W_Data_0(wd0), .W_BE_0(be0),
        .Write_Reg_1(we1), .W_Addr_1(wa1), .W_Data_1(wd1), .W_BE_1(be1));
    regfile_mp #(.READ_LAT(1), .BYPASS(1), .DEPTH(24)) u_d2 (
        .clk(clk), .reset(reset), .R_Addr({ra1, ra0}), .R_Data(rdat[2]), .R_Valid(rvld[2]),
        .Write_Reg_0(we0), .W_Addr_0(wa0), .W_Data_0(wd0), .W_BE_0(be0),
        .Write_Reg_1(we1), .W_Addr_1(wa1), .W_Data_1(wd1), .W_BE_1(be1));
    regfile_mp #(.READ_LAT(1), .BYPASS(0), .DEPTH(32)) u_d3 (
        .clk(clk), .reset(reset), .R_Addr({ra1, ra0}), .R_Data(rdat[3]), .R_Valid(rvld[3]),
        .Write_Reg_0(we0), .W_Addr_0(wa0), .W_Data_0(wd0), .W_BE_0(be0),
        .Write_Reg_1(we1), .W_Addr_1(wa1), .W_Data_1(wd1), .W_BE_1(be1));

    task automatic next_cyc();
        @(posedge clk);
        #1;
        we0 = 1'b0; we1 = 1'b0; be0 = '0; be1 = '0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we0 = 1'b1; wa0 = a; wd0 = d; be0 = be;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we1 = 1'b1; wa1 = a; wd1 = d; be1 = be;
    endtask

    task automatic push(input int dut, input int port, input logic [31:0] d, input logic v,
                        input logic [63:0] tag, input bit lat_en);
        exp_t e;
        e.due  = cyc + ((lat_en && dut >= 2) ? 1 : 0);
        e.dut  = dut;
        e.port = port;
        e.d    = d;
        e.v    = v;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic exp4(input int port,
                        input logic [31:0] d0, input logic v0, input logic [31:0] d1, input logic v1,
                        input logic [31:0] d2, input logic v2, input logic [31:0] d3, input logic v3,
                        input logic [63:0] tag, input bit lat_en = 1'b1);
        push(0, port, d0, v0, tag, lat_en);
        push(1, port, d1, v1, tag, lat_en);
        push(2, port, d2, v2, tag, lat_en);
        push(3, port, d3, v3, tag, lat_en);
    endtask

    task automatic exp_all(input int port, input logic [31:0] d, input logic v,
                           input logic [63:0] tag, input bit lat_en = 1'b1);
        exp4(port, d, v, d, v, d, v, d, v, tag, lat_en);
    endtask

    always @(negedge clk) begin
        int i;
        exp_t e;
        logic [63:0] dw;
        logic [1:0]  vw;
        logic [31:0] gd;
        logic        gv;
        i = 0;
        while (i < sbq.size()) begin
            e = sbq[i];
            if (e.due > cyc) begin
                i++;
            end else begin
                sbq.delete(i);
                total++;
                if (e.due < cyc) begin
                    bad++;
                    $display("FAIL %s dut%0d p%0d: check missed its cycle", e.tag, e.dut, e.port);
                end else begin
                    dw = rdat[e.dut];
                    vw = rvld[e.dut];
                    gd = dw[e.port*32 +: 32];
                    gv = vw[e.port];
                    if (gd !== e.d || gv !== e.v) begin
                        bad++;
                        $display("FAIL %s dut%0d p%0d: got data=%h valid=%b, want data=%h valid=%b",
                                 e.tag, e.dut, e.port, gd, gv, e.d, e.v);
                    end
                end
            end
        end
    end

    initial begin
        next_cyc();
        next_cyc();
        exp_all(0, 32'h0, 1'b0, "rst_p0", 1'b0);
        exp_all(1, 32'h0, 1'b0, "rst_p1", 1'b0);
        next_cyc();
        reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            ra1 = 5'(31 - a);
            exp_all(0, 32'h0, (a == 0), "init_p0");
            exp_all(1, 32'h0, (a == 31), "init_p1");
            next_cyc();
        end

        wr1(5'd1, 32'h12345678, 4'hF); ra0 = 5'd1; ra1 = 5'd2;
        exp4(0, 32'h12345678, 1, 32'h0, 0, 32'h12345678, 1, 32'h0, 0, "wr_r1");
        exp_all(1, 32'h0, 1'b0, "r2_empty");
        next_cyc();

        wr1(5'd2, 32'h87654321, 4'hF); ra0 = 5'd1; ra1 = 5'd2;
        exp_all(0, 32'h12345678, 1'b1, "rd_r1");
        exp4(1, 32'h87654321, 1, 32'h0, 0, 32'h87654321, 1, 32'h0, 0, "wr_r2");
        next_cyc();

        wr1(5'd0, 32'hFFFFFFFF, 4'hF); ra0 = 5'd0; ra1 = 5'd2;
        exp_all(0, 32'h0, 1'b1, "wr_r0");
        exp_all(1, 32'h87654321, 1'b1, "rd_r2");
        next_cyc();

        wr0(5'd5, 32'hAAAAAAAA, 4'hF); ra0 = 5'd5; ra1 = 5'd0;
        exp4(0, 32'hAAAAAAAA, 1, 32'h0, 0, 32'hAAAAAAAA, 1, 32'h0, 0, "wr_r5");
        exp_all(1, 32'h0, 1'b1, "rd_r0");
        next_cyc();

        wr0(5'd5, 32'h11111111, 4'hF); wr1(5'd5, 32'h22222222, 4'h3); ra0 = 5'd5; ra1 = 5'd5;
        exp4(0, 32'h11112222, 1, 32'hAAAAAAAA, 1, 32'h11112222, 1, 32'hAAAAAAAA, 1, "coll_p0");
        exp4(1, 32'h11112222, 1, 32'hAAAAAAAA, 1, 32'h11112222, 1, 32'hAAAAAAAA, 1, "coll_p1");
        next_cyc();

        ra0 = 5'd5; ra1 = 5'd1;
        exp_all(0, 32'h11112222, 1'b1, "coll_rd");
        exp_all(1, 32'h12345678, 1'b1, "rd_r1b");
        next_cyc();

        wr0(5'd7, 32'hFFFFFFFF, 4'h0); wr1(5'd6, 32'hCAFEBABE, 4'h4); ra0 = 5'd7; ra1 = 5'd6;
        exp_all(0, 32'h0, 1'b0, "be_zero");
        exp4(1, 32'h00FE0000, 1, 32'h0, 0, 32'h00FE0000, 1, 32'h0, 0, "be_part");
        next_cyc();

        wr1(5'd31, 32'h9ABCDEF0, 4'hF); ra0 = 5'd31; ra1 = 5'd6;
        exp4(0, 32'h9ABCDEF0, 1, 32'h0, 0, 32'h0, 0, 32'h0, 0, "byp_r31");
        exp_all(1, 32'h00FE0000, 1'b1, "rd_r6");
        next_cyc();

        wr0(5'd21, 32'h9890ACFE, 4'hF); ra0 = 5'd31; ra1 = 5'd21;
        exp4(0, 32'h9ABCDEF0, 1, 32'h9ABCDEF0, 1, 32'h0, 0, 32'h9ABCDEF0, 1, "rd_r31");
        exp4(1, 32'h9890ACFE, 1, 32'h0, 0, 32'h9890ACFE, 1, 32'h0, 0, "wr_r21");
        next_cyc();

        wr1(5'd21, 32'h01020304, 4'hF); ra0 = 5'd2; ra1 = 5'd21;
        exp_all(0, 32'h87654321, 1'b1, "rd_r2b");
        exp4(1, 32'h01020304, 1, 32'h9890ACFE, 1, 32'h01020304, 1, 32'h9890ACFE, 1, "wfirst");
        next_cyc();

        ra0 = 5'd21; ra1 = 5'd31;
        exp_all(0, 32'h01020304, 1'b1, "rd_r21");
        exp4(1, 32'h9ABCDEF0, 1, 32'h9ABCDEF0, 1, 32'h0, 0, 32'h9ABCDEF0, 1, "rd_r31b");
        next_cyc();
        next_cyc();

        ra0 = 5'd21; ra1 = 5'd1;
        #2 reset = 1'b0;
        exp_all(0, 32'h0, 1'b0, "arst_p0", 1'b0);
        exp_all(1, 32'h0, 1'b0, "arst_p1", 1'b0);
        next_cyc();

        wr1(5'd3, 32'hFFFFFFFF, 4'hF); ra0 = 5'd3;
        exp_all(0, 32'h0, 1'b0, "rst_wr", 1'b0);
        next_cyc();

        reset = 1'b1; ra0 = 5'd3; ra1 = 5'd21;
        exp_all(0, 32'h0, 1'b0, "post_r3");
        exp_all(1, 32'h0, 1'b0, "post_r21");
        next_cyc();

        ra0 = 5'd31; ra1 = 5'd0;
        exp_all(0, 32'h0, 1'b0, "post_r31");
        exp_all(1, 32'h0, 1'b1, "post_r0");
        next_cyc();

        ra0 = 5'd1; ra1 = 5'd2;
        exp_all(0, 32'h0, 1'b0, "post_r1");
        exp_all(1, 32'h0, 1'b0, "post_r2");
        next_cyc();
        next_cyc();
        next_cyc();

        if (sbq.size() != 0) begin
            total += sbq.size();
            bad   += sbq.size();
            $display("FAIL drain: %0d checks left unchecked, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the 2-read/1-write RegisterFile used in the CPU datapath.
- Adds the following:
  - configurable width, depth and read-port count
  - two write ports with per-byte enables and fixed priority
  - optional hardwired-zero register 0
  - write-first bypass
  - optional registered read stage
  - per-register "written since reset" valid bits
- Sits between decode (addresses) and execute/writeback (data); port 1 is the writeback port, port 0 the secondary (e.g. load/multicycle) port.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width.
- DEPTH, 32, number of registers; DEPTH <= 2^ADDR_W.
- NUM_RD, 2, number of read ports; 1..4.
- READ_LAT, 0, read latency: 0 = combinational, 1 = registered.
- BYPASS, 1, 1 = write-first forwarding of same-cycle writes to reads.
- ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- R_Addr, in, NUM_RD*ADDR_W, read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- R_Data, out, NUM_RD*DATA_W, read data; port i at bits [i*DATA_W +: DATA_W].
- R_Valid, out, NUM_RD, 1 = the addressed register has been written since reset.
- Write_Reg_0, in, 1, write enable, port 0.
- W_Addr_0, in, ADDR_W, write address, port 0.
- W_Data_0, in, DATA_W, write data, port 0.
- W_BE_0, in, DATA_W/8, byte enables, port 0.
- Write_Reg_1, in, 1, write enable, port 1.
- W_Addr_1, in, ADDR_W, write address, port 1.
- W_Data_1, in, DATA_W, write data, port 1.
- W_BE_1, in, DATA_W/8, byte enables, port 1.

Behaviour:
- Reset:
  - reset low asynchronously clears all registers to 0 and all valid bits to 0.
  - With READ_LAT=1, the R_Data and R_Valid pipeline registers also clear to 0.
  - Outputs are 0 while reset is held low.
  - Writes presented while reset is low are dropped.
  - Reset asserted mid-write (same cycle as a write edge) takes priority; no write lands.
- Effective write of port k:
  - Requires Write_Reg_k=1, W_Addr_k < DEPTH, and not (ZERO_R0 and W_Addr_k==0).
  - Only bytes with W_BE_k[b]=1 are updated; other bytes hold.
  - The valid bit of the target register is set if any byte enable is 1.
  - Write_Reg_k=1 with W_BE_k all-zero is a no-op; the valid bit is not set.
- Same address on both ports in one cycle:
  - Per byte, port 1 wins where W_BE_1[b]=1.
  - Port 0 bytes land only where W_BE_1[b]=0.
- Different addresses: both writes land on the same edge.
- Read value (READ_LAT=0):
  - R_Data_i = stored[R_Addr_i], combinational.
  - When BYPASS=1 and an effective write targets R_Addr_i this cycle, R_Data_i equals the post-merge value (the same byte rules as the write).
  - R_Valid_i is forwarded likewise.
  - When BYPASS=0, the old value is shown until after the edge.
- Read value (READ_LAT=1):
  - R_Data_i is captured at the rising edge and is valid one cycle after the address.
  - With BYPASS=1 the capture sees the value being written on that same edge (write-first).
  - With BYPASS=0 it sees the pre-edge value (read-first).
- Reads of address >= DEPTH return 0 with R_Valid=0.
- Reads of register 0 when ZERO_R0=1 return 0 with R_Valid=1.
- Read ports are fully independent; any number may address the same register.
- No internal FSM beyond the storage array, valid bits and the optional read pipeline.
- Combinational paths exist from R_Addr (and from the write ports when BYPASS=1) to R_Data only when READ_LAT=0.

Test Plan:
1. Reset held low, then released. Read all 32 addresses on both ports → R_Data=0x00000000, R_Valid=0 everywhere except r0 (R_Valid=1).
2. Single full-byte writes: port 1 writes r1=0x12345678, then r2=0x87654321; read r1/r2 next cycle → the values match, R_Valid=1. Any write to r0=0xFFFFFFFF reads back 0.
3. Byte-enable collision:
   - r5 holds 0xAAAAAAAA.
   - Same cycle: port 0 writes r5=0x11111111 with BE=1111; port 1 writes r5=0x22222222 with BE=0011.
   - Expected result: r5=0x11112222.
4. Bypass (READ_LAT=0, BYPASS=1):
   - Port 1 writes r31=0x9ABCDEF0 while R_Addr_0=31 in the same cycle → R_Data_0=0x9ABCDEF0 before the edge.
   - With BYPASS=0 → the old value is shown until after the edge.
5. READ_LAT=1, write-first:
   - r21=0x9890ACFE.
   - Rewrite r21=0x01020304 while reading r21 on the same edge → the next cycle shows 0x01020304 (BYPASS=1) or 0x9890ACFE (BYPASS=0).
6. Mid-run asynchronous reset:
   - r1, r2, r21 and r31 are populated.
   - Pull reset low between clock edges → R_Data goes to 0 immediately without a clock edge; after release, all reads = 0 with R_Valid=0.
   - With DEPTH=24, read r31 → returns 0 with R_Valid=0.
